shared_reg_arbiter: RTL

- Round-robin write arbiter for the shared 8-bit register (`I`/`Q`, loads every rising `Clk`).
- Sits directly in front of the register: drives the register input with the winning requester's data while granted, and with the register's own output otherwise, so the register holds its value between writes.
- Up to `NUM_REQ` producers share one register without write collisions.
- Optional bus lock: a requester can own the register for a bounded burst of cycles.

---
 rtl/shared_reg_arb_pkg.sv | 14 +
 rtl/shared_reg_arbiter_rr_pick.sv | 31 +++
 rtl/shared_reg_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM state
// encodings and default data/requester dimensions.
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_REQ = 4;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of a shared register; feeds Reg_Q back
// while no grant is active. Bus lock is built only with SHARED_REG_ARB_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_LOCK = 15
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ-1:0]         Lock,
  input  logic [NUM_REQ*WIDTH-1:0]   Data,
  input  logic [WIDTH-1:0]           Reg_Q,
  output logic [WIDTH-1:0]           Reg_I,
  output logic [NUM_REQ-1:0]         Gnt,
  output logic [$clog2(NUM_REQ)-1:0] Owner,
  output logic                       Busy
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      ptr_q;
  logic               busy_q;

  logic [OW-1:0]      next_ptr;
  logic [OW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [OW-1:0]      pick_idx;
  logic               pick_valid;
  logic               lock_own;

  assign next_ptr = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // From IDLE the stored pointer is current; while granted, the pointer is
  // about to become owner+1, so arbitrate with that value directly.
  assign pick_ptr = (state_q == IDLE) ? ptr_q : next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (OW)
  ) u_pick (
    .req   (Req),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef SHARED_REG_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q;
  assign lock_own = Lock[owner_q];
`else
  localparam int unsigned unused_max_lock = MAX_LOCK;
  logic unused_lock;
  assign unused_lock = ^Lock;
  assign lock_own    = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef SHARED_REG_ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          ptr_q <= next_ptr;
          if (lock_own) begin
            state_q <= LOCKED;
`ifdef SHARED_REG_ARB_LOCK_EN
            cnt_q   <= CW'(1);
`endif
          end else if (pick_valid) begin
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
`ifdef SHARED_REG_ARB_LOCK_EN
        LOCKED: begin
          if (!lock_own || cnt_q == CW'(MAX_LOCK)) begin
            cnt_q <= '0;
            if (pick_valid) begin
              state_q <= GRANT;
              gnt_q   <= pick_gnt;
              owner_q <= pick_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Gnt   = gnt_q;
  assign Owner = owner_q;
  assign Busy  = busy_q;
  assign Reg_I = (|gnt_q) ? Data[owner_q*WIDTH +: WIDTH] : Reg_Q;

endmodule
